// File: rtl/snn_soc_pkg.sv
// SoC-wide constants shared by the UART transmit controller and its users.
// Latency: n/a (constants only).
// Backpressure: n/a.
package snn_soc_pkg;

  // Interconnect decodes the base; the UART only looks at the low nibble.
  localparam logic [31:0] UART_BASE = 32'h4000_0200;

  // Register offsets within the UART window.
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  // Divider defaults: 100 MHz core clock / 115200 baud.
  localparam int BAUD_DIV_W_DEF = 16;
  localparam int RESET_BAUD_DIV = 868;

endpackage

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART transmitter with programmable per-bit divider.
// Latency: start bit drives uart_tx from the edge that accepts TXDATA; reads are same-cycle.
// Backpressure: none; TXDATA writes while busy are silently dropped (poll STATUS.tx_busy).
module uart_ctrl #(
  parameter int BAUD_DIV_W     = snn_soc_pkg::BAUD_DIV_W_DEF,
  parameter int RESET_BAUD_DIV = snn_soc_pkg::RESET_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx
);

  import snn_soc_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [BAUD_DIV_W-1:0] DIV_ONE = BAUD_DIV_W'(1);

  tx_state_e             tx_state_q, tx_state_d;
  logic [BAUD_DIV_W-1:0] baud_div_q, baud_div_d;
  logic [BAUD_DIV_W-1:0] div_eff_q, div_eff_d;
  logic [BAUD_DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // Names kept stable for hierarchical probing.
  tx_state_e tx_state;
  logic      tx_busy;
  assign tx_state = tx_state_q;
  assign tx_busy  = busy_q;
  assign uart_tx  = tx_q;

  logic wr_acc, txdata_wr, ctrl_wr, bit_done;
  assign wr_acc    = req_valid && req_write;
  assign txdata_wr = wr_acc && (req_addr[3:0] == OFF_TXDATA) && req_wstrb[0];
  assign ctrl_wr   = wr_acc && (req_addr[3:0] == OFF_CTRL);
  assign bit_done  = (cnt_q == div_eff_q - DIV_ONE);

  // uart_rx is reserved in this revision; undecoded address/data bits are ignored.
  logic unused_inputs;
  assign unused_inputs = ^{uart_rx, req_addr[31:4], req_wdata[31:BAUD_DIV_W], req_wstrb[3:2]};

  // State register plus all datapath flops; uart_tx and busy come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      baud_div_q <= BAUD_DIV_W'(RESET_BAUD_DIV);
      div_eff_q  <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      baud_div_q <= baud_div_d;
      div_eff_q  <= div_eff_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // CTRL divider, byte-lane masked; a mid-frame change only affects the next frame.
  always_comb begin
    baud_div_d = baud_div_q;
    if (ctrl_wr) begin
      for (int i = 0; i < BAUD_DIV_W; i++) begin
        if (req_wstrb[i/8]) baud_div_d[i] = req_wdata[i];
      end
    end
  end

  // Next-state: bit timing counter, bit index and shift register advance together.
  always_comb begin
    tx_state_d = tx_state_q;
    div_eff_d  = div_eff_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    unique case (tx_state_q)
      IDLE: begin
        if (txdata_wr) begin
          tx_state_d = START;
          shift_d    = req_wdata[7:0];
          div_eff_d  = (baud_div_q == '0) ? DIV_ONE : baud_div_q;
          cnt_d      = '0;
          bit_idx_d  = '0;
        end
      end
      START: begin
        if (bit_done) begin
          tx_state_d = DATA;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end
      STOP: begin
        if (bit_done) begin
          tx_state_d = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered line changes on the transition edge.
  always_comb begin
    busy_d = (tx_state_d != IDLE);
    tx_d   = 1'b1;
    if (tx_state_d == START)     tx_d = 1'b0;
    else if (tx_state_d == DATA) tx_d = shift_d[0];
  end

  // Combinational read mux, zero unless a read is presented this cycle.
  always_comb begin
    rdata = '0;
    if (req_valid && !req_write) begin
      case (req_addr[3:0])
        OFF_STATUS: rdata[0] = busy_q;
        OFF_CTRL:   rdata[BAUD_DIV_W-1:0] = baud_div_q;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: register table, frame decode, drop and reset corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_ctrl;
  import snn_soc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rdata;
  logic        uart_rx;
  logic        uart_tx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rdata     (rdata),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The receive pin toggles freely; it must never influence anything.
  initial begin
    uart_rx = 1'b1;
    forever begin
      @(negedge clk);
      uart_rx = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    bit          vld;
    bit          wr;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit vld, bit wr, logic [3:0] off, logic [31:0] wdata,
                              logic [3:0] strb, logic [31:0] exp);
    vec_t v;
    v.vld = vld; v.wr = wr; v.off = off; v.wdata = wdata; v.strb = strb; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic bus_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] strb);
    req_valid = 1'b1; req_write = 1'b1;
    req_addr  = UART_BASE | {28'h0, off};
    req_wdata = data; req_wstrb = strb;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    req_valid = 1'b1; req_write = 1'b0;
    req_addr  = UART_BASE | {28'h0, off};
    #1 data = rdata;
    req_valid = 1'b0;
  endtask

  task automatic idle_check(input int cycles, input string nm);
    int bad = 0;
    for (int k = 0; k < cycles; k++) begin
      if (uart_tx !== 1'b1 || dut.tx_busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check(nm, bad, 0);
  endtask

  // Sends byte b and compares the whole line against the ideal 8N1 waveform with d cycles
  // per bit. Optionally injects one extra write (ik = cycle offset within the frame).
  task automatic run_frame(input logic [7:0] b, input int d, input int ik,
                           input logic [3:0] ioff, input logic [31:0] idat, input logic [3:0] istb);
    logic [9:0] fr;
    logic [7:0] dec;
    logic       st_bit, sp_bit;
    int         bad, busy_cnt, total;
    string      tag;
    tag      = $sformatf("frame_%02h_d%0d", b, d);
    fr       = {1'b1, b, 1'b0};
    total    = 10 * d;
    bad      = 0;
    busy_cnt = 0;
    dec      = '0;
    st_bit   = 1'bx;
    sp_bit   = 1'bx;
    bus_write(OFF_TXDATA, {8'($urandom), 8'($urandom), 8'($urandom), b}, 4'b0001 | 4'($urandom));
    for (int k = 0; k < total; k++) begin
      if (k == ik) begin
        req_valid = 1'b1; req_write = 1'b1;
        req_addr  = UART_BASE | {28'h0, ioff};
        req_wdata = idat; req_wstrb = istb;
      end
      if (uart_tx !== fr[k/d]) bad++;
      if (dut.tx_busy === 1'b1) busy_cnt++;
      if (k == d/2) st_bit = uart_tx;
      if (k >= d && k < 9*d && (k % d) == d/2) dec[k/d - 1] = uart_tx;
      if (k == 9*d + d/2) sp_bit = uart_tx;
      @(posedge clk); #1;
      if (k == ik) begin
        req_valid = 1'b0; req_write = 1'b0;
      end
    end
    check({tag, "_wave"}, bad, 0);
    check({tag, "_busy_cycles"}, busy_cnt, total);
    check({tag, "_decode"}, {24'h0, dec}, {24'h0, b});
    check({tag, "_start"}, {31'h0, st_bit}, 32'h0);
    check({tag, "_stop"}, {31'h0, sp_bit}, 32'h1);
    check({tag, "_end_idle"}, {30'h0, dut.tx_busy, uart_tx}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int model_baud, d, mode, ik, nb;
    logic [7:0] byte_v;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_busy", {31'h0, dut.tx_busy}, 32'h0);
    check("rst_state", 32'(dut.tx_state), 32'h0);

    // Register map vectors.
    vecs.push_back(mk(1, 0, OFF_CTRL,   32'h0,         4'h0, 32'd868));
    vecs.push_back(mk(1, 0, OFF_STATUS, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 0, OFF_TXDATA, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 4'hC,       32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(0, 0, OFF_CTRL,   32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 1, OFF_CTRL,   32'h8,         4'h3, 32'h0));
    vecs.push_back(mk(1, 0, OFF_CTRL,   32'h0,         4'h0, 32'h8));
    vecs.push_back(mk(1, 1, OFF_CTRL,   32'hFFFF_1234, 4'h1, 32'h0));
    vecs.push_back(mk(1, 0, OFF_CTRL,   32'h0,         4'h0, 32'h34));
    vecs.push_back(mk(1, 1, OFF_CTRL,   32'hABCD_56FF, 4'h2, 32'h0));
    vecs.push_back(mk(1, 0, OFF_CTRL,   32'h0,         4'h0, 32'h5634));
    vecs.push_back(mk(1, 1, OFF_CTRL,   32'hFFFF_FFFF, 4'hC, 32'h0));
    vecs.push_back(mk(1, 0, OFF_CTRL,   32'h0,         4'h0, 32'h5634));
    vecs.push_back(mk(1, 1, OFF_STATUS, 32'hFFFF_FFFF, 4'hF, 32'h0));
    vecs.push_back(mk(1, 0, OFF_STATUS, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 4'hC,       32'hFFFF_FFFF, 4'hF, 32'h0));
    vecs.push_back(mk(1, 0, 4'hC,       32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 0, OFF_CTRL,   32'h0,         4'h0, 32'h5634));
    vecs.push_back(mk(1, 1, OFF_TXDATA, 32'h55,        4'hE, 32'h0));
    vecs.push_back(mk(1, 0, OFF_STATUS, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1, 1, OFF_CTRL,   32'h0001_0008, 4'hF, 32'h0));
    vecs.push_back(mk(1, 0, OFF_CTRL,   32'h0,         4'h0, 32'h8));

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].off, vecs[i].wdata, vecs[i].strb);
      end else begin
        req_valid = vecs[i].vld; req_write = 1'b0;
        req_addr  = UART_BASE | {28'h0, vecs[i].off};
        #1 check($sformatf("vec%0d_rd_off%0h", i, vecs[i].off), rdata, vecs[i].exp);
        req_valid = 1'b0;
      end
    end

    // Baseline frames at divider 8.
    run_frame(8'h55, 8, -1, 4'h0, 32'h0, 4'h0);
    run_frame(8'hA5, 8, -1, 4'h0, 32'h0, 4'h0);
    run_frame(8'hFF, 8, -1, 4'h0, 32'h0, 4'h0);
    run_frame(8'h00, 8, -1, 4'h0, 32'h0, 4'h0);

    // Busy is visible the cycle after the write and clears well before 120 cycles.
    bus_write(OFF_TXDATA, 32'hAA, 4'h1);
    bus_read(OFF_STATUS, rd);
    check("status_busy_next_cycle", rd, 32'h1);
    repeat (119) @(posedge clk);
    #1;
    bus_read(OFF_STATUS, rd);
    check("status_idle_after_120", rd, 32'h0);

    // Second write one cycle after the first is dropped; nothing follows the frame.
    run_frame(8'hBB, 8, 0, OFF_TXDATA, 32'h3C, 4'h1);
    idle_check(30, "no_second_frame");
    run_frame(8'h3C, 8, -1, 4'h0, 32'h0, 4'h0);

    // Write coinciding with the final STOP edge is dropped; the very next cycle is accepted.
    run_frame(8'h96, 8, 79, OFF_TXDATA, 32'h77, 4'h1);
    run_frame(8'h69, 8, -1, 4'h0, 32'h0, 4'h0);

    // CTRL written mid-frame: current frame keeps 8, next one uses 3.
    run_frame(8'h5A, 8, 20, OFF_CTRL, 32'h3, 4'h3);
    bus_read(OFF_CTRL, rd);
    check("ctrl_after_midframe_write", rd, 32'h3);
    run_frame(8'hC3, 3, -1, 4'h0, 32'h0, 4'h0);

    // Divider 0 behaves as 1: ten-cycle frame.
    bus_write(OFF_CTRL, 32'h0, 4'h3);
    run_frame(8'h81, 1, -1, 4'h0, 32'h0, 4'h0);
    bus_read(4'hC, rd);
    check("offset_c_reads_zero", rd, 32'h0);

    // Randomised frames, divider changes and stray writes against the ideal waveform.
    model_baud = 2;
    bus_write(OFF_CTRL, 32'(model_baud), 4'h3);
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        model_baud = $urandom_range(0, 5);
        bus_write(OFF_CTRL, {16'($urandom), 16'(model_baud)}, 4'h3);
      end
      d      = (model_baud == 0) ? 1 : model_baud;
      byte_v = 8'($urandom);
      mode   = $urandom_range(0, 2);
      ik     = $urandom_range(0, 10*d - 1);
      if (mode == 0) begin
        run_frame(byte_v, d, -1, 4'h0, 32'h0, 4'h0);
      end else if (mode == 1) begin
        run_frame(byte_v, d, ik, OFF_TXDATA, $urandom, 4'h1);
      end else begin
        nb = $urandom_range(0, 5);
        run_frame(byte_v, d, ik, OFF_CTRL, 32'(nb), 4'h3);
        model_baud = nb;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset in the middle of a frame aborts it immediately.
    bus_write(OFF_CTRL, 32'h8, 4'h3);
    bus_write(OFF_TXDATA, 32'hE7, 4'h1);
    repeat (25) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("midrst_busy", {31'h0, dut.tx_busy}, 32'h0);
    check("midrst_state", 32'(dut.tx_state), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus_read(OFF_CTRL, rd);
    check("midrst_ctrl_default", rd, 32'd868);
    bus_read(OFF_STATUS, rd);
    check("midrst_status", rd, 32'h0);
    idle_check(20, "midrst_stays_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
